ddr3_read_capture_ctrl: RTL



---
 rtl/ddr3_read_capture_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ddr3_read_capture_ctrl.sv
// Read-capture control for one ddr3_ring_buffer8: times the listen pulse after CAS latency,
// drains the eight captured beats into a 128-bit word and offers it over valid/ready.
module ddr3_read_capture_ctrl #(
    parameter int CL_CYCLES     = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int TAG_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_busy,
    output logic              rd_overrun,
    output logic              listen,
    output logic [2:0]        readPtr,
    input  logic [15:0]       din,
    output logic [127:0]      data_out,
    output logic [TAG_W-1:0]  data_tag,
    output logic              data_valid,
    input  logic              data_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CL,
        LISTEN,
        SETTLE,
        DRAIN,
        OUTPUT
    } state_t;

    // WAIT_CL lasts CL_CYCLES-1 cycles so LISTEN lands exactly CL_CYCLES after the issue cycle.
    localparam logic [4:0] CL_LOAD     = 5'((CL_CYCLES > 1) ? (CL_CYCLES - 2) : 0);
    localparam logic [4:0] SETTLE_LOAD = 5'(SETTLE_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [4:0]         cnt_reg, cnt_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [TAG_W-1:0]   tag_reg, tag_next;
    logic               listen_reg;
    logic               busy_reg;
    logic               overrun_reg;
    logic               valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        tag_next   = tag_reg;
        case (state_reg)
            IDLE: begin
                if (rd_issue) begin
                    tag_next   = rd_tag;
                    cnt_next   = CL_LOAD;
                    state_next = (CL_CYCLES > 1) ? WAIT_CL : LISTEN;
                end
            end
            WAIT_CL: begin
                if (cnt_reg == 5'd0) begin
                    state_next = LISTEN;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            LISTEN: begin
                cnt_next   = SETTLE_LOAD;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt_reg == 5'd0) begin
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            DRAIN: begin
                // readPtr doubles as the beat counter; it parks at 0 outside DRAIN.
                if (ptr_reg == 3'd7) begin
                    ptr_next   = 3'd0;
                    state_next = OUTPUT;
                end else begin
                    ptr_next = ptr_reg + 3'd1;
                end
            end
            OUTPUT: begin
                if (data_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 5'd0;
            ptr_reg     <= 3'd0;
            tag_reg     <= '0;
            listen_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
            tag_reg     <= tag_next;
            listen_reg  <= (state_next == LISTEN);
            busy_reg    <= (state_next != IDLE);
            overrun_reg <= rd_issue && (state_reg != IDLE);
            valid_reg   <= (state_next == OUTPUT);
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_beat
            logic [15:0] beat_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    beat_reg <= 16'd0;
                end else if (state_reg == DRAIN && ptr_reg == 3'(gi)) begin
                    beat_reg <= din;
                end
            end

            assign data_out[gi*16 +: 16] = beat_reg;
        end
    endgenerate

    assign rd_busy    = busy_reg;
    assign rd_overrun = overrun_reg;
    assign listen     = listen_reg;
    assign readPtr    = ptr_reg;
    assign data_tag   = tag_reg;
    assign data_valid = valid_reg;

endmodule
